// File: rtl/apb_acc_master_pkg.sv
// Shared types and constants for the single-outstanding APB initiator.
// Provides the FSM state type, the timeout read-data pattern and the counter sizing helper.
package apb_acc_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

    // Width needed to hold the value TIMEOUT_CYCLES itself; never narrower than one bit.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_acc_master.sv
// Single-outstanding APB initiator: valid/ready command in, APB setup/access out,
// registered response with PSLVERR capture and a programmable hung-transfer timeout.
module apb_acc_master
    import apb_acc_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic                      cmd_write,
    input  logic [31:0]               cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int unsigned          CNT_W     = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]     TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit                   TMO_EN    = (TIMEOUT_CYCLES != 0);

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      write_q, write_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      tmo_q, tmo_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = {cmd_addr[APB_ADDR_WIDTH-1:2], 2'b00};
                    write_d = cmd_write;
                    wdata_d = cmd_write ? cmd_wdata : '0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over an expiring timeout in the same cycle.
                if (PREADY) begin
                    rdata_d = write_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if (TMO_EN && (cnt_q == TMO_LIMIT)) begin
                    rdata_d = ERR_RDATA;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;
    assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE     = (state_q == ACCESS);
    assign PADDR       = addr_q;
    assign PWDATA      = wdata_q;
    assign PWRITE      = write_q;

endmodule

// File: tb/tb_apb_acc_master.sv
// Randomized scoreboard bench for apb_acc_master: a driver pushes expected responses,
// a slave model answers APB transfers, and a monitor pops and compares each response.
module tb_apb_acc_master;

    localparam int unsigned AW  = 12;
    localparam int unsigned TMO = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    always #5 HCLK = ~HCLK;

    apb_acc_master #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    typedef struct {
        logic [31:0]   rdata;
        logic          err;
        logic          tmo;
        int unsigned   lat;
        int unsigned   stall;
        int unsigned   acc_cyc;
        logic [AW-1:0] paddr;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    // Plan for the transfer currently owned by the slave model.
    logic [AW-1:0] p_addr  = '0;
    logic          p_write = 1'b0;
    logic [31:0]   p_wdata = '0;
    logic [31:0]   p_rdata = '0;
    logic          p_err   = 1'b0;
    int unsigned   p_waits = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge HCLK);
        cyc++;
    end

    // APB slave model: PREADY goes high on ACCESS cycle index p_waits (0-based).
    initial begin
        int unsigned idx;
        idx = 0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                idx = 0;
                PREADY = 1'b0;
            end else if (PSEL) begin
                check("apb_paddr",  32'(PADDR),  32'(p_addr));
                check("apb_pwrite", 32'(PWRITE), 32'(p_write));
                check("apb_pwdata", PWDATA, p_wdata);
                if (PENABLE) begin
                    PREADY  = (idx == p_waits);
                    PRDATA  = PREADY ? p_rdata : $urandom;
                    PSLVERR = PREADY ? p_err : 1'($urandom);
                    idx++;
                end else begin
                    idx = 0;
                    PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
                end
            end else begin
                idx = 0;
                PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin
        bit          seen;
        int unsigned resp_cyc;
        exp_t        e;
        seen = 0; resp_cyc = 0; rsp_ready = 1'b0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                seen = 0;
                rsp_ready = 1'b0;
            end else if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rsp got=rsp_valid exp=none (t=%0t)", $time);
                    rsp_ready = 1'b1;
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        check("rsp_latency", cyc - e.acc_cyc, e.lat);
                        seen = 1;
                        resp_cyc = 0;
                    end
                    check("rsp_rdata",   rsp_rdata, e.rdata);
                    check("rsp_err",     32'(rsp_err), 32'(e.err));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                    check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
                    check("resp_psel",      32'({PSEL, PENABLE}), 32'd0);
                    check("resp_paddr_hold", 32'(PADDR), 32'(e.paddr));
                    resp_cyc++;
                    rsp_ready = (resp_cyc > e.stall) && ($urandom_range(0, 3) != 0);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        seen = 0;
                    end
                end
            end else begin
                rsp_ready = 1'($urandom);
            end
        end
    end

    task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                         input int unsigned waits, input logic [31:0] rd, input logic er,
                         input int unsigned stall, input bit expect_rsp);
        int unsigned t;
        exp_t        e;
        bit          normal;
        t = 0;
        @(negedge HCLK);
        while (!cmd_ready && t < 200) begin
            @(negedge HCLK);
            t++;
        end
        if (!cmd_ready) begin
            n_tests++; n_fail++;
            $display("FAIL cmd_ready_wait got=0 exp=1 (t=%0t)", $time);
            return;
        end
        p_addr  = addr & ~AW'(3);
        p_write = wr;
        p_wdata = wr ? wd : 32'd0;
        p_rdata = rd;
        p_err   = er;
        p_waits = waits;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr; cmd_wdata = wd;
        @(posedge HCLK);
        #1;
        cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_write = 1'($urandom); cmd_wdata = $urandom;
        if (expect_rsp) begin
            // PREADY on ACCESS index TMO still wins; later than that the timeout fires.
            normal    = (waits <= TMO);
            e.rdata   = !normal ? 32'hFFFF_FFFF : (wr ? 32'd0 : rd);
            e.err     = normal ? er : 1'b1;
            e.tmo     = !normal;
            e.lat     = 2 + (normal ? waits : TMO);
            e.stall   = stall;
            e.acc_cyc = cyc;
            e.paddr   = p_addr;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int unsigned t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge HCLK);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"},   32'(cmd_ready),   32'd1);
        check({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
        check({tag, "_rsp_rdata"},   rsp_rdata,        32'd0);
        check({tag, "_rsp_err"},     32'({rsp_err, rsp_timeout}), 32'd0);
        check({tag, "_paddr"},       32'(PADDR),       32'd0);
        check({tag, "_pwdata"},      PWDATA,           32'd0);
        check({tag, "_pwrite"},      32'(PWRITE),      32'd0);
        check({tag, "_psel"},        32'(PSEL),        32'd0);
        check({tag, "_penable"},     32'(PENABLE),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset_outputs("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;

        issue(12'h004, 1'b1, 32'hA1B2C3D4, 0,  32'h0BAD_F00D, 1'b0, 0, 1'b1);
        issue(12'h00C, 1'b0, $urandom,     3,  32'h12345678, 1'b0, 0, 1'b1);
        issue(12'h00E, 1'b0, $urandom,     3,  32'h12345678, 1'b0, 0, 1'b1);
        issue(12'h010, 1'b0, $urandom,     1,  32'hDEADBEEF, 1'b1, 0, 1'b1);
        issue(12'h020, 1'b0, $urandom,     99, 32'h00000055, 1'b0, 0, 1'b1);
        issue(12'h025, 1'b1, 32'h11112222, 99, 32'h0,        1'b0, 0, 1'b1);
        issue(12'h028, 1'b0, $urandom,     3,  32'hCAFE0001, 1'b0, 0, 1'b1);
        issue(12'h02C, 1'b0, $urandom,     4,  32'hCAFE0002, 1'b1, 0, 1'b1);
        issue(12'h030, 1'b0, $urandom,     5,  32'hCAFE0003, 1'b0, 0, 1'b1);
        issue(12'h034, 1'b1, 32'h00000077, 2,  32'h0,        1'b0, 5, 1'b1);
        drain();

        // Reset pulsed in the middle of an ACCESS phase: transfer dropped, no response.
        issue(12'h100, 1'b1, 32'h5A5A5A5A, 99, 32'h0, 1'b0, 0, 1'b0);
        t = 0;
        while (!PENABLE && t < 20) begin
            @(negedge HCLK);
            t++;
        end
        check("rst_reach_access", 32'(PENABLE), 32'd1);
        @(negedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (8) begin
            @(negedge HCLK);
            check("post_rst_no_rsp", 32'({rsp_valid, PSEL}), 32'd0);
        end
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            logic          w;
            int unsigned   ws;
            a  = AW'($urandom);
            w  = 1'($urandom);
            ws = ($urandom_range(0, 6) == 0) ? 99 : $urandom_range(0, 6);
            issue(a, w, $urandom, ws, $urandom, ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 3), 1'b1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
